// File: rtl/bary_interp_if.sv
// Handshake and data bundle between the barycentric coordinate stage,
// the attribute interpolator and the pixel writer.
interface bary_interp_if #(
   parameter int NCH = 4,
   parameter int AW  = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [15:0]         alpha;
   logic [15:0]         beta;
   logic [15:0]         gamma;
   logic [NCH*AW-1:0]   attr0;
   logic [NCH*AW-1:0]   attr1;
   logic [NCH*AW-1:0]   attr2;
   logic                out_valid;
   logic                out_ready;
   logic [NCH*AW-1:0]   out_attr;
   logic                out_degen;

   modport master (
      output in_valid, alpha, beta, gamma, attr0, attr1, attr2, out_ready,
      input  in_ready, out_valid, out_attr, out_degen
   );

   modport slave (
      input  in_valid, alpha, beta, gamma, attr0, attr1, attr2, out_ready,
      output in_ready, out_valid, out_attr, out_degen
   );
endinterface

// File: rtl/bary_interp.sv
// Barycentric attribute interpolator: one shared multiplier, weighted sum of
// three vertex attribute vectors per channel, rounded and saturated.
//
// state   | meaning
// --------+-----------------------------------------------------------
// st_idle | waiting for an input transaction, in_ready high
// st_mac  | issuing one multiply per cycle, accumulating per channel
// st_done | result presented, held until out_ready
module bary_interp #(
   parameter int NCH = 4,
   parameter int AW  = 8
) (
   input logic        clk,
   input logic        rst,
   bary_interp_if.slave bus
);
   localparam int ACCW = AW + 18;
   localparam int PW   = 16 + AW;
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {st_idle, st_mac, st_done} state_t;
   state_t state, state_nx;

   logic [15:0]        w0, w1, w2;
   logic [NCH*AW-1:0]  a0, a1, a2;
   logic [1:0]         v;
   logic [CW-1:0]      ch;
   logic               iss_en;
   logic               iss_last;
   logic               take;

   logic [PW-1:0]      prod;
   logic               p_valid, p_last, p_final;
   logic [CW-1:0]      p_ch;

   logic [ACCW-1:0]    acc, acc_sum, acc_rnd;
   logic [AW+2:0]      res_sh;
   logic [AW-1:0]      res_sat;
   logic [15:0]        w_sel;
   logic [NCH*AW-1:0]  a_vec;
   logic [AW-1:0]      a_sel;

   function automatic logic [15:0] clamp(input logic [15:0] w);
      return (w > 16'h8000) ? 16'h8000 : w;
   endfunction

   assign take     = (state == st_idle) && bus.in_valid;
   assign iss_last = (v == 2'd2) && (ch == CW'(NCH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= st_idle;
      else     state <= state_nx;
   end

   // The product is registered before accumulation, so MAC drains one cycle
   // after the last multiply is issued.
   always_comb begin
      state_nx = state;
      case (state)
         st_idle: if (bus.in_valid)           state_nx = st_mac;
         st_mac:  if (p_valid && p_final)     state_nx = st_done;
         st_done: if (bus.out_ready)          state_nx = st_idle;
         default:                             state_nx = st_idle;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == st_idle) && !rst;
      bus.out_valid = (state == st_done);
   end

   always_comb begin
      w_sel = w0;
      a_vec = a0;
      case (v)
         2'd1:    begin w_sel = w1; a_vec = a1; end
         2'd2:    begin w_sel = w2; a_vec = a2; end
         default: begin w_sel = w0; a_vec = a0; end
      endcase
      a_sel   = a_vec[ch*AW +: AW];
      acc_sum = acc + ACCW'(prod);
      acc_rnd = acc_sum + ACCW'(1 << 14);
      res_sh  = acc_rnd[ACCW-1:15];
      res_sat = (|res_sh[AW+2:AW]) ? {AW{1'b1}} : res_sh[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w0 <= '0; w1 <= '0; w2 <= '0;
         a0 <= '0; a1 <= '0; a2 <= '0;
         v <= '0; ch <= '0; iss_en <= 1'b0;
         prod <= '0; p_valid <= 1'b0; p_last <= 1'b0; p_final <= 1'b0; p_ch <= '0;
         acc <= '0;
         bus.out_attr  <= '0;
         bus.out_degen <= 1'b0;
      end else begin
         p_valid <= 1'b0;
         if (take) begin
            w0 <= clamp(bus.alpha);
            w1 <= clamp(bus.beta);
            w2 <= clamp(bus.gamma);
            a0 <= bus.attr0;
            a1 <= bus.attr1;
            a2 <= bus.attr2;
            bus.out_degen <= (bus.alpha == 16'h0) && (bus.beta == 16'h0) && (bus.gamma == 16'h0);
            v <= '0;
            ch <= '0;
            acc <= '0;
            iss_en <= 1'b1;
         end
         if (state == st_mac) begin
            if (iss_en) begin
               prod    <= PW'(w_sel) * PW'(a_sel);
               p_valid <= 1'b1;
               p_last  <= (v == 2'd2);
               p_final <= iss_last;
               p_ch    <= ch;
               if (v == 2'd2) begin
                  v  <= '0;
                  ch <= (ch == CW'(NCH - 1)) ? '0 : ch + 1'b1;
               end else begin
                  v <= v + 2'd1;
               end
               if (iss_last) iss_en <= 1'b0;
            end
            if (p_valid) begin
               if (p_last) begin
                  acc <= '0;
                  bus.out_attr[p_ch*AW +: AW] <= res_sat;
               end else begin
                  acc <= acc_sum;
               end
            end
         end
      end
   end
endmodule
